ntwrk_topk_prod: RTL and testbench

- Sequential top-K network-size product unit; successor to the combinational network-size product stage.
- Accepts a stream of network sizes from the point-network stage and keeps the K largest in a sorted register array.
- At end of stream, multiplies the K entries one per cycle and presents the answer with a valid/ready handshake.
- Removes the wide single-cycle multiply chain. Adds arbitrary network count, top-K selection, overflow flagging and back-to-back runs.

---
 rtl/ntwrk_topk_prod.sv | 150 +++++++++++++++
 tb/tb_ntwrk_topk_prod.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ntwrk_topk_prod.sv
// ntwrk_topk_prod: streaming top-K network-size product unit.
// Collects a stream of network sizes, keeps the K largest in a descending
// sorted register array, then multiplies them one per cycle and presents the
// product on a valid/ready handshake.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   sz_in/sz_vld/sz_rdy  size stream (sz_last marks the final beat of a run)
//   answer/answer_vld    product of the top-K sizes, handshaked by answer_rdy
//   ovf                  product exceeded PROD_W bits (valid with answer_vld)
module ntwrk_topk_prod #(
  parameter int unsigned K      = 3,
  parameter int unsigned SZ_W   = 11,
  parameter int unsigned PROD_W = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SZ_W-1:0]   sz_in,
  input  logic              sz_vld,
  input  logic              sz_last,
  output logic              sz_rdy,
  output logic [PROD_W-1:0] answer,
  output logic              answer_vld,
  input  logic              answer_rdy,
  output logic              ovf
);

  localparam int unsigned FW       = SZ_W + PROD_W;
  localparam int unsigned IDX_W    = (K < 2) ? 1 : $clog2(K + 1);
  localparam int unsigned LAST_IDX = (K < 2) ? 1 : K - 1;

  typedef enum logic [1:0] {COLLECT, MULT, DONE} state_t;

  state_t              state;
  logic [SZ_W-1:0]     slot [K];
  logic [K-1:0]        slot_vld;
  logic [PROD_W-1:0]   acc;
  logic [IDX_W-1:0]    idx;
  logic                ovf_run;

  logic [K-1:0]        ge;
  logic [SZ_W-1:0]     ins_slot [K];
  logic [K-1:0]        ins_vld;
  logic [FW-1:0]       mul_a;
  logic [FW-1:0]       mul_b;
  logic [FW-1:0]       prod;
  logic [PROD_W-1:0]   prod_lo;
  logic                prod_hi_nz;

  // Sorted insertion. Valid slots form a descending prefix, so the slots that
  // are >= the new value are themselves a prefix; the new value lands just
  // after it and the remainder shifts down one place. When every slot is
  // valid and >= the value, nothing changes (value discarded).
  always_comb begin
    for (int i = 0; i < int'(K); i++) begin
      ge[i] = slot_vld[i] && (slot[i] >= sz_in);
    end
    ins_slot[0] = ge[0] ? slot[0] : sz_in;
    ins_vld[0]  = 1'b1;
    for (int i = 1; i < int'(K); i++) begin
      if (ge[i]) begin
        ins_slot[i] = slot[i];
        ins_vld[i]  = 1'b1;
      end else if (ge[i-1]) begin
        ins_slot[i] = sz_in;
        ins_vld[i]  = 1'b1;
      end else begin
        ins_slot[i] = slot[i-1];
        ins_vld[i]  = slot_vld[i-1];
      end
    end
  end

  // Multiply step: first step starts from slot0 (0 if empty), later steps
  // from acc. The multiplicand slot[idx] counts as 1 when empty.
  always_comb begin
    mul_b = FW'(1);
    for (int i = 1; i < int'(K); i++) begin
      if (idx == IDX_W'(i)) begin
        mul_b = slot_vld[i] ? FW'(slot[i]) : FW'(1);
      end
    end
    if (idx == IDX_W'(1)) begin
      mul_a = slot_vld[0] ? FW'(slot[0]) : FW'(0);
    end else begin
      mul_a = FW'(acc);
    end
    prod       = mul_a * mul_b;
    prod_lo    = prod[PROD_W-1:0];
    prod_hi_nz = |prod[FW-1:PROD_W];
  end

  // Control, slot array and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= COLLECT;
      sz_rdy     <= 1'b1;
      answer     <= '0;
      answer_vld <= 1'b0;
      ovf        <= 1'b0;
      ovf_run    <= 1'b0;
      acc        <= '0;
      idx        <= '0;
      slot_vld   <= '0;
      for (int i = 0; i < int'(K); i++) slot[i] <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (sz_vld && sz_rdy) begin
            slot_vld <= ins_vld;
            for (int i = 0; i < int'(K); i++) slot[i] <= ins_slot[i];
            if (sz_last) begin
              state  <= MULT;
              sz_rdy <= 1'b0;
              idx    <= IDX_W'(1);
            end
          end
        end
        MULT: begin
          acc     <= prod_lo;
          ovf_run <= ovf_run | prod_hi_nz;
          idx     <= idx + IDX_W'(1);
          if (idx >= IDX_W'(LAST_IDX)) begin
            state      <= DONE;
            answer     <= prod_lo;
            ovf        <= ovf_run | prod_hi_nz;
            answer_vld <= 1'b1;
          end
        end
        DONE: begin
          if (answer_rdy) begin
            state      <= COLLECT;
            sz_rdy     <= 1'b1;
            answer_vld <= 1'b0;
            ovf        <= 1'b0;
            ovf_run    <= 1'b0;
            acc        <= '0;
            idx        <= '0;
            slot_vld   <= '0;
            for (int i = 0; i < int'(K); i++) slot[i] <= '0;
          end
        end
        default: begin
          state  <= COLLECT;
          sz_rdy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntwrk_topk_prod.sv
// Bench for ntwrk_topk_prod: three instances (default, K=1, PROD_W=16) share
// the size bus; a run-level model predicts handshake timing and the product.
module tb_ntwrk_topk_prod;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] sz_in;
  logic        sz_last;
  logic        answer_rdy;
  logic        sz_vld_a   [3];
  logic        sz_rdy_a   [3];
  logic        answer_vld_a [3];
  logic        ovf_a      [3];
  logic [32:0] answer_a   [3];
  logic [32:0] ans0;
  logic [32:0] ans1;
  logic [15:0] ans2;

  always #5 clk = ~clk;

  ntwrk_topk_prod #(.K(3), .SZ_W(11), .PROD_W(33)) u_main (
    .clk(clk), .rst_n(rst_n), .sz_in(sz_in), .sz_vld(sz_vld_a[0]),
    .sz_last(sz_last), .sz_rdy(sz_rdy_a[0]), .answer(ans0),
    .answer_vld(answer_vld_a[0]), .answer_rdy(answer_rdy), .ovf(ovf_a[0]));

  ntwrk_topk_prod #(.K(1), .SZ_W(11), .PROD_W(33)) u_k1 (
    .clk(clk), .rst_n(rst_n), .sz_in(sz_in), .sz_vld(sz_vld_a[1]),
    .sz_last(sz_last), .sz_rdy(sz_rdy_a[1]), .answer(ans1),
    .answer_vld(answer_vld_a[1]), .answer_rdy(answer_rdy), .ovf(ovf_a[1]));

  ntwrk_topk_prod #(.K(3), .SZ_W(11), .PROD_W(16)) u_pw16 (
    .clk(clk), .rst_n(rst_n), .sz_in(sz_in), .sz_vld(sz_vld_a[2]),
    .sz_last(sz_last), .sz_rdy(sz_rdy_a[2]), .answer(ans2),
    .answer_vld(answer_vld_a[2]), .answer_rdy(answer_rdy), .ovf(ovf_a[2]));

  always_comb begin
    answer_a[0] = ans0;
    answer_a[1] = ans1;
    answer_a[2] = 33'(ans2);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- run-level model ----------------
  int     k_of  [3] = '{3, 1, 3};
  int     pw_of [3] = '{33, 33, 16};
  int     vals  [3][32];
  int     nvals [3];
  int     phase [3];          // 0 collecting, 1 multiplying, 2 answer held
  int     cnt   [3];
  longint exp_ans [3];
  bit     exp_ovf [3];
  bit     started = 1'b0;

  // Product of the K largest accepted sizes, truncated after every multiply.
  function automatic void top_k_product(input int inst, output longint res, output bit o);
    int     v [32];
    int     n;
    int     t;
    longint a;
    longint full;
    longint b;
    longint mask;
    n = nvals[inst];
    for (int i = 0; i < 32; i++) v[i] = vals[inst][i];
    for (int i = 0; i < n; i++)
      for (int j = i + 1; j < n; j++)
        if (v[j] > v[i]) begin t = v[i]; v[i] = v[j]; v[j] = t; end
    mask = (64'd1 << pw_of[inst]) - 64'd1;
    o = 1'b0;
    a = (n > 0) ? longint'(v[0]) : 64'd0;
    if (k_of[inst] == 1) begin
      o = (a >> pw_of[inst]) != 0;
      a = a & mask;
    end else begin
      for (int j = 1; j < k_of[inst]; j++) begin
        b = (j < n) ? longint'(v[j]) : 64'd1;
        full = a * b;
        if ((full >> pw_of[inst]) != 0) o = 1'b1;
        a = full & mask;
      end
    end
    res = a;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      started = 1'b1;
      for (int i = 0; i < 3; i++) begin
        phase[i] = 0; nvals[i] = 0; cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        case (phase[i])
          0: if (sz_vld_a[i]) begin
               vals[i][nvals[i]] = int'(sz_in);
               nvals[i]++;
               if (sz_last) begin
                 top_k_product(i, exp_ans[i], exp_ovf[i]);
                 phase[i] = 1;
                 cnt[i] = (k_of[i] > 2) ? k_of[i] - 1 : 1;
               end
             end
          1: begin
               cnt[i]--;
               if (cnt[i] == 0) phase[i] = 2;
             end
          default: if (answer_rdy) begin
               phase[i] = 0;
               nvals[i] = 0;
             end
        endcase
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("sz_rdy[%0d]", i), longint'(sz_rdy_a[i]), longint'(phase[i] == 0));
        chk($sformatf("answer_vld[%0d]", i), longint'(answer_vld_a[i]), longint'(phase[i] == 2));
        if (answer_vld_a[i] && phase[i] == 2) begin
          chk($sformatf("answer[%0d]", i), longint'(answer_a[i]), exp_ans[i]);
          chk($sformatf("ovf[%0d]", i), longint'(ovf_a[i]), longint'(exp_ovf[i]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int inst, input int v [], input int n);
    int waited;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      waited = 0;
      while (!sz_rdy_a[inst] && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 50) chk("send_rdy_timeout", 0, 1);
      sz_in          = 11'(v[j]);
      sz_vld_a[inst] = 1'b1;
      sz_last        = (j == n - 1);
    end
    @(negedge clk);
    sz_vld_a[inst] = 1'b0;
    sz_last        = 1'b0;
  endtask

  // Called on the negedge right after the last acceptance edge.
  task automatic wait_answer(input int inst, input string name, input longint ea,
                             input bit eo, input int elat);
    int n;
    n = 1;
    while (!answer_vld_a[inst] && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!answer_vld_a[inst]) begin
      chk({name, "_timeout"}, 0, 1);
    end else begin
      chk({name, "_answer"}, longint'(answer_a[inst]), ea);
      chk({name, "_ovf"}, longint'(ovf_a[inst]), longint'(eo));
      chk({name, "_latency"}, longint'(n - 1), longint'(elat));
    end
  endtask

  initial begin
    int v [];
    rst_n = 1'b0; sz_in = '0; sz_last = 1'b0; answer_rdy = 1'b1;
    for (int i = 0; i < 3; i++) sz_vld_a[i] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sz_rdy", longint'(sz_rdy_a[0]), 1);
    chk("rst_answer_vld", longint'(answer_vld_a[0]), 0);
    chk("rst_answer", longint'(answer_a[0]), 0);
    chk("rst_ovf", longint'(ovf_a[0]), 0);
    rst_n = 1'b1;

    // basic run
    v = '{2, 5, 1, 4, 2, 1};
    send(0, v, 6);
    wait_answer(0, "basic", 40, 1'b0, 2);
    @(negedge clk);
    chk("basic_vld_one_cycle", longint'(answer_vld_a[0]), 0);
    chk("basic_rdy_after", longint'(sz_rdy_a[0]), 1);

    // ties, then a short run
    v = '{3, 7, 7, 7};
    send(0, v, 4);
    wait_answer(0, "ties", 343, 1'b0, 2);
    v = '{7, 3};
    send(0, v, 2);
    wait_answer(0, "two_nets", 21, 1'b0, 2);

    // single zero; K=1 single beat
    v = '{0};
    send(0, v, 1);
    wait_answer(0, "zero", 0, 1'b0, 2);
    v = '{9};
    send(1, v, 1);
    wait_answer(1, "k1", 9, 1'b0, 1);

    // narrow product overflow
    v = '{2047, 2047, 2047};
    send(2, v, 3);
    wait_answer(2, "ovf16", 6143, 1'b1, 2);

    // backpressure
    repeat (2) @(negedge clk);
    answer_rdy = 1'b0;
    v = '{6, 6, 6};
    send(0, v, 3);
    wait_answer(0, "bp", 216, 1'b0, 2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold_answer", longint'(answer_a[0]), 216);
      chk("bp_hold_rdy", longint'(sz_rdy_a[0]), 0);
    end
    answer_rdy = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", longint'(sz_rdy_a[0]), 1);
    v = '{2, 3};
    send(0, v, 2);
    wait_answer(0, "bp_second", 6, 1'b0, 2);

    // reset during MULT
    repeat (2) @(negedge clk);
    v = '{10, 10, 10};
    send(0, v, 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("rstmid_no_vld", longint'(answer_vld_a[0]), 0);
      @(negedge clk);
    end
    chk("rstmid_answer", longint'(answer_a[0]), 0);
    chk("rstmid_ovf", longint'(ovf_a[0]), 0);
    v = '{4, 5};
    send(0, v, 2);
    wait_answer(0, "after_rst", 20, 1'b0, 2);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
